// File: rtl/store_buffer_pkg.sv
// Shared widths and constants for the MEM-stage store buffer.
package store_buffer_pkg;

  localparam int WORD_W      = 32;
  localparam int DMEM_ADDR_W = 16;
  localparam int SB_DEPTH    = 4;

  localparam logic [WORD_W-1:0] WORD_ZERO = '0;

endpackage

// File: rtl/store_buffer_sb_match.sv
// Lookup of a load address against buffered stores; reports the youngest
// valid entry whose word address matches.
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]                  valid_i,
  input  logic [DEPTH-1:0][DMEM_ADDR_W-1:0] addr_i,
  input  logic [PW-1:0]                     head_i,
  input  logic [DMEM_ADDR_W-1:0]            lookup_i,
  output logic                              hit_o,
  output logic [PW-1:0]                     idx_o
);

  logic [PW-1:0] idx;
  logic          unused_bits;

  assign unused_bits = ^{lookup_i[1:0], addr_i};

  // Walk from the slot just before head (the newest possible) back to head.
  always_comb begin
    hit_o = 1'b0;
    idx_o = head_i;
    idx   = head_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = head_i + PW'(k);
      if (!hit_o && valid_i[idx] &&
          addr_i[idx][DMEM_ADDR_W-1:2] == lookup_i[DMEM_ADDR_W-1:2]) begin
        hit_o = 1'b1;
        idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO between MEM stage and data memory: drains in program order on
// idle cycles, forwards loads that hit buffered stores, stalls only when full.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              stall,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              empty,
  output logic              full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][DMEM_ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][WORD_W-1:0]      data_q;
  logic [PW-1:0]                     head_q, head_d;
  logic [PW-1:0]                     tail_q, tail_d;
  logic [CW-1:0]                     count_q, count_d;

  logic [DEPTH-1:0] valid;
  logic             match_hit;
  logic [PW-1:0]    match_idx;
  logic             buf_empty, buf_full;
  logic             load_hit, load_miss, drain, enq, deq;
  logic             unused_addr;

  assign unused_addr = ^{cpu_addr[WORD_W-1:DMEM_ADDR_W]};

  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, PW'(PW'(i) - head_q)} < count_q;
    end
  end

  sb_match #(.DEPTH(DEPTH)) u_match (
    .valid_i  (valid),
    .addr_i   (addr_q),
    .head_i   (head_q),
    .lookup_i (cpu_addr[DMEM_ADDR_W-1:0]),
    .hit_o    (match_hit),
    .idx_o    (match_idx)
  );

  assign buf_empty = (count_q == '0);
  assign buf_full  = (count_q == CW'(DEPTH));

  assign load_hit  = cpu_read & match_hit;
  assign load_miss = cpu_read & ~match_hit;
  // A full buffer always drains, so the one-cycle stall frees a slot.
  assign drain     = ~rst & ~buf_empty & (buf_full | (~cpu_read & ~cpu_write));
  assign enq       = ~rst & cpu_write & ~buf_full;
  assign deq       = drain;

  assign empty = rst | buf_empty;
  assign full  = ~rst & buf_full;
  assign stall = ~rst & buf_full & (cpu_write | load_miss);

  always_comb begin
    mem_write = 1'b0;
    mem_read  = 1'b0;
    mem_addr  = WORD_ZERO;
    mem_wdata = WORD_ZERO;
    if (drain) begin
      mem_write = 1'b1;
      mem_addr  = {{(WORD_W-DMEM_ADDR_W){1'b0}}, addr_q[head_q]};
      mem_wdata = data_q[head_q];
    end else if (!rst && load_miss && !buf_full) begin
      mem_read  = 1'b1;
      mem_addr  = cpu_addr;
    end
  end

  always_comb begin
    cpu_rdata = WORD_ZERO;
    if (!rst && cpu_read && !stall) begin
      cpu_rdata = load_hit ? data_q[match_idx] : mem_rdata;
    end
  end

  always_comb begin
    head_d  = head_q + PW'(deq);
    tail_d  = tail_q + PW'(enq);
    count_d = count_q + CW'(enq) - CW'(deq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= cpu_addr[DMEM_ADDR_W-1:0];
      data_q[tail_q] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a drain-order scoreboard.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_read, cpu_write, stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, empty, full;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mid-cycle sample: scoreboard drains and record accepted stores.
  task automatic sample();
    ent_t e;
    @(negedge clk);
    if (rst) begin
      sb.delete();
    end else begin
      if (mem_write) begin
        if (sb.size() == 0) begin
          chk("drain_spurious", {31'b0, mem_write}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("drain_addr", mem_addr, {16'h0, e.a});
          chk("drain_data", mem_wdata, e.d);
        end
      end
      if (cpu_write && !stall) sb.push_back({cpu_addr[15:0], cpu_wdata});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = a; cpu_wdata = d;
    sample();
    chk("store_stall", {31'b0, stall}, 32'h0);
    tick();
  endtask

  task automatic load_setup(input logic [31:0] a);
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = a; cpu_wdata = '0;
  endtask

  task automatic drain_all(input int budget);
    idle();
    for (int i = 0; i < budget; i++) begin
      if (empty === 1'b1) break;
      sample();
      tick();
    end
    chk("drained_empty", {31'b0, empty}, 32'h1);
    chk("sb_left", sb.size(), 32'h0);
  endtask

  initial begin
    rst = 1'b1; mem_rdata = 32'hDEADBEEF;
    idle();
    cpu_read = 1'b1; cpu_addr = 32'h0000_0010;
    sample(); tick();
    sample();
    chk("rst_empty", {31'b0, empty}, 32'h1);
    chk("rst_full", {31'b0, full}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    tick();
    rst = 1'b0;
    idle();

    // Single store then idle drain
    store(32'h4, 32'h0000FFFF);
    idle();
    sample();
    chk("single_mem_write", {31'b0, mem_write}, 32'h1);
    chk("single_mem_addr", mem_addr, 32'h4);
    chk("single_mem_wdata", mem_wdata, 32'h0000FFFF);
    tick();
    sample();
    chk("single_empty_after", {31'b0, empty}, 32'h1);
    chk("single_no_write", {31'b0, mem_write}, 32'h0);
    tick();

    // Fill, full stall for one cycle, in-order drains
    for (int i = 0; i < 4; i++) store(32'h10 + 4 * i, 32'hA000_0010 + 4 * i);
    cpu_write = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hA000_0020;
    sample();
    chk("full_flag", {31'b0, full}, 32'h1);
    chk("full_stall", {31'b0, stall}, 32'h1);
    chk("full_drain_addr", mem_addr, 32'h10);
    tick();
    sample();
    chk("full_retry_stall", {31'b0, stall}, 32'h0);
    chk("full_retry_no_drain", {31'b0, mem_write}, 32'h0);
    tick();
    drain_all(10);

    // Forwarding from the youngest of two same-address stores
    store(32'h2C, 32'hFFFF0000);
    store(32'h2C, 32'h12345678);
    load_setup(32'h2C);
    sample();
    chk("fwd_rdata", cpu_rdata, 32'h12345678);
    chk("fwd_mem_read", {31'b0, mem_read}, 32'h0);
    chk("fwd_stall", {31'b0, stall}, 32'h0);
    tick();
    drain_all(10);

    // Load miss with one entry buffered
    store(32'h10, 32'h11111111);
    mem_rdata = 32'hCAFEF00D;
    load_setup(32'h0C);
    sample();
    chk("miss_mem_read", {31'b0, mem_read}, 32'h1);
    chk("miss_mem_addr", mem_addr, 32'h0C);
    chk("miss_rdata", cpu_rdata, 32'hCAFEF00D);
    chk("miss_no_drain", {31'b0, mem_write}, 32'h0);
    tick();
    drain_all(10);

    // Load miss against a full buffer stalls and drains
    for (int i = 0; i < 4; i++) store(32'h40 + 4 * i, 32'hB000_0040 + 4 * i);
    load_setup(32'h0C);
    sample();
    chk("fullmiss_stall", {31'b0, stall}, 32'h1);
    chk("fullmiss_mem_read", {31'b0, mem_read}, 32'h0);
    chk("fullmiss_drain", {31'b0, mem_write}, 32'h1);
    chk("fullmiss_rdata", cpu_rdata, 32'h0);
    tick();
    sample();
    chk("fullmiss_retry_stall", {31'b0, stall}, 32'h0);
    chk("fullmiss_retry_rdata", cpu_rdata, 32'hCAFEF00D);
    tick();
    drain_all(10);

    // Reset with three entries queued: none may ever drain
    for (int i = 0; i < 3; i++) store(32'h60 + 4 * i, 32'hC000_0060 + 4 * i);
    idle();
    rst = 1'b1;
    sample();
    chk("midrst_mem_write", {31'b0, mem_write}, 32'h0);
    chk("midrst_empty", {31'b0, empty}, 32'h1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample();
      tick();
    end
    chk("postrst_empty", {31'b0, empty}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
